// File: rtl/rs232_ctrl_pkg.sv
// Shared definitions for the serial-port bus controller.
//   reg_addr_e  : peripheral register map (DATA / STATUS / CTRL / reserved)
//   ST_* / CTRL_*: bit positions inside the STATUS and CTRL registers
//   tx_state_e  : states of the transmit sequencer
package rs232_ctrl_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_addr_e;

  localparam int unsigned ST_RX_NONEMPTY = 0;
  localparam int unsigned ST_TX_FULL     = 1;
  localparam int unsigned ST_RX_OVERRUN  = 2;
  localparam int unsigned ST_TX_IDLE     = 3;
  localparam int unsigned ST_TX_OVERFLOW = 4;

  localparam int unsigned CTRL_RX_IRQ_EN = 0;
  localparam int unsigned CTRL_TX_IRQ_EN = 1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOAD,
    TX_SEND,
    TX_HOLD,
    TX_WAIT
  } tx_state_e;

endpackage

// File: rtl/rs232_fifo.sv
// Synchronous FIFO used for both the RX and TX byte queues.
//   clock, rst : system clock, asynchronous active-high reset
//   push/wr_data : write request and data (ignored when full unless popping)
//   pop         : read request (ignored when empty)
//   rd_data     : head entry, valid while !empty
//   full/empty/count : occupancy, count is LOG2+1 bits
module rs232_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LOG2  = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LOG2:0]    count
);

  localparam int unsigned DEPTH = 1 << LOG2;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LOG2-1:0]  wr_ptr;
  logic [LOG2-1:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (LOG2+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (LOG2+1)'(1);
        2'b01:   count <= count - (LOG2+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rs232_ctrl.sv
// Bus-side controller for the serial port.
//   clock, rst       : system clock, asynchronous active-high reset
//   addr, rd_strobe, wr_strobe, wr_data, rd_data : peripheral register bus
//                      (DATA, STATUS, CTRL; rd_data valid the cycle after rd_strobe)
//   rx_attention, rx_byte : byte-valid pulse and byte from the RS-232 receiver
//   tx_data, tx_valid, tx_busy : byte, start pulse and busy flag of the transmitter
//   irq              : registered level interrupt
module rs232_ctrl
  import rs232_ctrl_pkg::*;
#(
  parameter int unsigned RX_LOG2 = 4,
  parameter int unsigned TX_LOG2 = 4
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        rd_strobe,
  input  logic        wr_strobe,
  input  logic [7:0]  wr_data,
  output logic [31:0] rd_data,
  input  logic        rx_attention,
  input  logic [7:0]  rx_byte,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_busy,
  output logic        irq
);

  reg_addr_e          sel;
  logic               data_rd, data_wr, status_wr, ctrl_wr;

  logic               rx_full, rx_empty, rx_pop;
  logic [7:0]         rx_head;
  logic [RX_LOG2:0]   rx_count;

  logic               tx_full, tx_empty, tx_pop;
  logic [7:0]         tx_head;
  logic [TX_LOG2:0]   tx_count;

  logic               rx_overrun, tx_overflow;
  logic [1:0]         ctrl;
  logic               tx_idle;
  logic [31:0]        status_word, rd_mux;

  tx_state_e          state, state_next;

  assign sel       = reg_addr_e'(addr);
  assign data_rd   = rd_strobe & (sel == REG_DATA);
  assign data_wr   = wr_strobe & (sel == REG_DATA);
  assign status_wr = wr_strobe & (sel == REG_STATUS);
  assign ctrl_wr   = wr_strobe & (sel == REG_CTRL);
  assign rx_pop    = data_rd & ~rx_empty;

  rs232_fifo #(.WIDTH(8), .LOG2(RX_LOG2)) u_rx_fifo (
    .clock   (clock),
    .rst     (rst),
    .push    (rx_attention),
    .wr_data (rx_byte),
    .pop     (rx_pop),
    .rd_data (rx_head),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count)
  );

  rs232_fifo #(.WIDTH(8), .LOG2(TX_LOG2)) u_tx_fifo (
    .clock   (clock),
    .rst     (rst),
    .push    (data_wr),
    .wr_data (wr_data),
    .pop     (tx_pop),
    .rd_data (tx_head),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (tx_count)
  );

  // Transmit sequencer: one byte at a time, HOLD masks the cycle in which the
  // transmitter has not yet raised tx_busy after the start pulse.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= TX_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    tx_pop     = 1'b0;
    tx_valid   = 1'b0;
    case (state)
      TX_IDLE: if (!tx_empty) state_next = TX_LOAD;
      TX_LOAD: begin
        tx_pop     = 1'b1;
        state_next = TX_SEND;
      end
      TX_SEND: if (!tx_busy) begin
        tx_valid   = 1'b1;
        state_next = TX_HOLD;
      end
      TX_HOLD: state_next = TX_WAIT;
      TX_WAIT: if (!tx_busy) state_next = TX_IDLE;
      default: state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst)                   tx_data <= '0;
    else if (state == TX_LOAD) tx_data <= tx_head;
  end

  assign tx_idle = tx_empty & (state == TX_IDLE) & ~tx_busy;

  // Sticky flags: a set event in the same cycle as a clear wins.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rx_overrun  <= 1'b0;
      tx_overflow <= 1'b0;
      ctrl        <= '0;
    end else begin
      if (rx_attention & rx_full & ~rx_pop)
        rx_overrun <= 1'b1;
      else if (status_wr & wr_data[ST_RX_OVERRUN])
        rx_overrun <= 1'b0;

      if (data_wr & tx_full & ~tx_pop)
        tx_overflow <= 1'b1;
      else if (status_wr & wr_data[ST_TX_OVERFLOW])
        tx_overflow <= 1'b0;

      if (ctrl_wr) ctrl <= wr_data[1:0];
    end
  end

  always_comb begin
    status_word                 = '0;
    status_word[ST_RX_NONEMPTY] = ~rx_empty;
    status_word[ST_TX_FULL]     = tx_full;
    status_word[ST_RX_OVERRUN]  = rx_overrun;
    status_word[ST_TX_IDLE]     = tx_idle;
    status_word[ST_TX_OVERFLOW] = tx_overflow;
    status_word[15:8]           = 8'(rx_count);
    status_word[23:16]          = 8'(tx_count);
  end

  // The head is sampled before this cycle's push lands, so a DATA read never
  // returns a byte arriving in the same cycle.
  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_DATA:   if (!rx_empty) rd_mux = {23'b0, 1'b1, rx_head};
      REG_STATUS: rd_mux = status_word;
      REG_CTRL:   rd_mux = {30'b0, ctrl};
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
      irq     <= 1'b0;
    end else begin
      if (rd_strobe) rd_data <= rd_mux;
      irq <= (ctrl[CTRL_RX_IRQ_EN] & ~rx_empty)
           | (ctrl[CTRL_TX_IRQ_EN] & tx_empty)
           | rx_overrun;
    end
  end

endmodule

// File: tb/tb_rs232_ctrl.sv
module tb_rs232_ctrl;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  addr = '0;
  logic        rd_strobe = 1'b0;
  logic        wr_strobe = 1'b0;
  logic [7:0]  wr_data = '0;
  logic [31:0] rd_data;
  logic        rx_attention = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_busy;
  logic        irq;

  logic        hold_busy = 1'b0;
  int unsigned busy_cnt = 0;

  rs232_ctrl #(.RX_LOG2(4), .TX_LOG2(4)) dut (
    .clock        (clock),
    .rst          (rst),
    .addr         (addr),
    .rd_strobe    (rd_strobe),
    .wr_strobe    (wr_strobe),
    .wr_data      (wr_data),
    .rd_data      (rd_data),
    .rx_attention (rx_attention),
    .rx_byte      (rx_byte),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_busy      (tx_busy),
    .irq          (irq)
  );

  always #5 clock = ~clock;

  // Transmitter stand-in: busy for 10 cycles after each start pulse,
  // or held busy on demand.
  always @(posedge clock) begin
    if (tx_valid)           busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = hold_busy | (busy_cnt != 0);

  // Reference model state
  logic [7:0]  m_rx[$];
  logic [7:0]  m_tx[$];
  logic        m_ovr = 1'b0, m_txo = 1'b0;
  logic [1:0]  m_ctrl = '0;
  logic        m_rd_chk = 1'b0;
  logic [31:0] m_rd_exp = '0, m_rd_mask = '1;
  logic        m_irq = 1'b0, m_irq_known = 1'b1;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_pulses = 0;
  logic [7:0]  sent[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp,
                     input logic [31:0] mask = '1);
    n_checks++;
    if ((act & mask) !== (exp & mask)) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (mask 0x%08h) at %0t",
               name, act, exp, mask, $time);
    end
  endtask

  // Outputs produced by the previous edge, against the model's prediction.
  task automatic compare();
    if (m_rd_chk) chk("rd_data", rd_data, m_rd_exp, m_rd_mask);
    if (m_irq_known) chk("irq", 32'(irq), 32'(m_irq));
    if (tx_valid) begin
      n_pulses++;
      sent.push_back(tx_data);
      chk("tx_pending_at_valid", 32'(m_tx.size() != 0), 32'd1);
      if (m_tx.size() != 0) chk("tx_data", 32'(tx_data), 32'(m_tx[0]));
      chk("tx_busy_at_valid", 32'(tx_busy), 32'd0);
    end
  endtask

  // Predict what the coming edge does, from the register-level rules.
  task automatic model_step();
    int         n;
    logic [7:0] b;
    logic       set_ovr, clr_ovr, set_txo, clr_txo;
    if (rst) begin
      m_rx.delete();
      m_tx.delete();
      m_ovr = 1'b0; m_txo = 1'b0; m_ctrl = '0;
      m_rd_chk = 1'b0; m_irq = 1'b0; m_irq_known = 1'b1;
    end else begin
      set_ovr = 1'b0; clr_ovr = 1'b0; set_txo = 1'b0; clr_txo = 1'b0;
      // tx-empty is not modelled, so irq is only predicted with tx_irq_en off
      m_irq_known = ~m_ctrl[1];
      m_irq       = (m_ctrl[0] && m_rx.size() != 0) || m_ovr;
      m_rd_chk    = rd_strobe;
      m_rd_mask   = '1;
      m_rd_exp    = '0;
      if (rd_strobe) begin
        case (addr)
          2'd0: if (m_rx.size() != 0) begin
            b = m_rx.pop_front();
            m_rd_exp = 32'h100 | {24'b0, b};
          end
          2'd1: begin
            n = m_rx.size();
            m_rd_exp  = (32'(n) << 8) | {27'b0, m_txo, 1'b0, m_ovr, 1'b0, n != 0};
            // tx_full, tx_idle and TX count are timing-dependent; pinned by literals
            m_rd_mask = 32'hFF00_FFF5;
          end
          2'd2: m_rd_exp = {30'b0, m_ctrl};
          default: m_rd_exp = '0;
        endcase
      end
      if (wr_strobe) begin
        case (addr)
          // 16 queued plus one held by the sequencer: every burst here starts
          // with the sequencer already holding a byte when the queue fills.
          2'd0: if (m_tx.size() < 17) m_tx.push_back(wr_data); else set_txo = 1'b1;
          2'd1: begin clr_ovr = wr_data[2]; clr_txo = wr_data[4]; end
          2'd2: m_ctrl = wr_data[1:0];
          default: ;
        endcase
      end
      if (tx_valid && m_tx.size() != 0) void'(m_tx.pop_front());
      if (rx_attention) begin
        if (m_rx.size() < 16) m_rx.push_back(rx_byte);
        else set_ovr = 1'b1;
      end
      if (clr_ovr) m_ovr = 1'b0;
      if (set_ovr) m_ovr = 1'b1;
      if (clr_txo) m_txo = 1'b0;
      if (set_txo) m_txo = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clock);
    compare();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
    addr = a; rd_strobe = 1'b1;
    tick();
    rd_strobe = 1'b0;
    v = rd_data;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    addr = a; wr_data = d; wr_strobe = 1'b1;
    tick();
    wr_strobe = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_attention = 1'b1; rx_byte = b;
    tick();
    rx_attention = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    logic        got;
    int          base;

    // Reset
    repeat (3) tick();
    chk("reset_rd_data", rd_data, 32'h0);
    chk("reset_tx_data", 32'(tx_data), 32'h0);
    chk("reset_tx_valid", 32'(tx_valid), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    rst = 1'b0;
    tick();
    bus_read(2'd1, v); chk("reset_status", v, 32'h0000_0008);

    // 1: two received bytes
    rx_pulse(8'h41);
    rx_pulse(8'h42);
    bus_read(2'd1, v); chk("t1_status", v, 32'h0000_0209);
    bus_read(2'd0, v); chk("t1_data0", v, 32'h0000_0141);
    bus_read(2'd0, v); chk("t1_data1", v, 32'h0000_0142);
    bus_read(2'd0, v); chk("t1_empty", v, 32'h0000_0000);

    // 2: RX overrun, clear racing a set, full pop+push
    for (int i = 0; i < 17; i++) rx_pulse(8'(8'h10 + i));
    addr = 2'd1; wr_data = 8'h04; wr_strobe = 1'b1; rx_attention = 1'b1; rx_byte = 8'hEE;
    tick();
    wr_strobe = 1'b0; rx_attention = 1'b0;
    bus_read(2'd1, v); chk("t2_status_ovr", v, 32'h0000_100D);
    bus_write(2'd1, 8'h04);
    bus_read(2'd1, v); chk("t2_status_clr", v, 32'h0000_1009);
    addr = 2'd0; rd_strobe = 1'b1; rx_attention = 1'b1; rx_byte = 8'h99;
    tick();
    rd_strobe = 1'b0; rx_attention = 1'b0;
    chk("t2_pop_push", rd_data, 32'h0000_0110);
    bus_read(2'd1, v); chk("t2_status_full", v, 32'h0000_1009);
    for (int i = 1; i < 16; i++) begin
      bus_read(2'd0, v); chk("t2_drain", v, 32'h100 | 32'(8'h10 + i));
    end
    bus_read(2'd0, v); chk("t2_last", v, 32'h0000_0199);
    bus_read(2'd0, v); chk("t2_empty", v, 32'h0000_0000);

    // 3: two transmitted bytes
    bus_write(2'd0, 8'h55);
    tick();
    chk("t3_valid_n2", 32'(tx_valid), 32'd0);
    tick();
    chk("t3_valid_n3", 32'(tx_valid), 32'd1);
    chk("t3_data_n3", 32'(tx_data), 32'h55);
    bus_write(2'd0, 8'hAA);
    for (int k = 0; k < 100 && !(n_pulses >= 2 && !tx_busy); k++) tick();
    repeat (3) tick();
    chk("t3_pulses", 32'(n_pulses), 32'd2);
    if (sent.size() >= 2) begin
      chk("t3_first", 32'(sent[0]), 32'h55);
      chk("t3_second", 32'(sent[1]), 32'hAA);
    end
    bus_read(2'd1, v); chk("t3_idle", v, 32'h0000_0008);

    // 4: TX overflow while the transmitter is stuck busy
    hold_busy = 1'b1;
    base = n_pulses;
    for (int i = 0; i < 18; i++) bus_write(2'd0, 8'(8'h60 + i));
    bus_read(2'd1, v); chk("t4_status_full", v, 32'h0010_0012);
    bus_write(2'd1, 8'h10);
    bus_read(2'd1, v); chk("t4_status_clr", v, 32'h0010_0002);
    hold_busy = 1'b0;
    for (int k = 0; k < 1000 && n_pulses < base + 17; k++) tick();
    repeat (30) tick();
    chk("t4_pulses", 32'(n_pulses - base), 32'd17);
    if (sent.size() >= base + 17) begin
      chk("t4_first", 32'(sent[base]), 32'h60);
      chk("t4_last", 32'(sent[base + 16]), 32'h70);
    end
    bus_read(2'd1, v); chk("t4_idle", v, 32'h0000_0008);

    // 5: interrupts and CTRL
    bus_write(2'd2, 8'h01);
    bus_read(2'd2, v); chk("t5_ctrl", v, 32'h0000_0001);
    rx_pulse(8'h77);
    got = 1'b0;
    for (int k = 0; k < 2 && !got; k++) begin tick(); got = irq; end
    chk("t5_irq_rise", 32'(got), 32'd1);
    bus_read(2'd0, v); chk("t5_data", v, 32'h0000_0177);
    got = 1'b1;
    for (int k = 0; k < 2 && got; k++) begin tick(); got = irq; end
    chk("t5_irq_fall", 32'(got), 32'd0);
    bus_write(2'd2, 8'h03);
    got = 1'b0;
    for (int k = 0; k < 2 && !got; k++) begin tick(); got = irq; end
    chk("t5_irq_tx_empty", 32'(got), 32'd1);
    bus_read(2'd2, v); chk("t5_ctrl3", v, 32'h0000_0003);
    bus_read(2'd3, v); chk("t5_reserved", v, 32'h0000_0000);
    bus_write(2'd2, 8'h00);
    repeat (3) tick();
    chk("t5_irq_off", 32'(irq), 32'd0);

    // 6: reset during SEND with bytes queued
    hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) bus_write(2'd0, 8'(8'h81 + i));
    repeat (5) tick();
    base = n_pulses;
    hold_busy = 1'b0;
    #1;
    chk("t6_valid_before", 32'(tx_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t6_valid_reset", 32'(tx_valid), 32'd0);
    chk("t6_data_reset", 32'(tx_data), 32'd0);
    chk("t6_rd_reset", rd_data, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    bus_read(2'd1, v); chk("t6_status", v, 32'h0000_0008);
    repeat (30) tick();
    chk("t6_no_pulse", 32'(n_pulses - base), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
